// File: rtl/memory_arbiter.sv
// Two-requester arbiter sharing one registered memory port between instruction
// fetch and data load/store, alternating grants so neither side starves.
module memory_arbiter #(
    parameter int ADDR_SIZE = 64,
    parameter int DATA_SIZE = 64,
    parameter int BYTE_NUM  = DATA_SIZE / 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 inst_rd_en,
    input  logic [ADDR_SIZE-1:0] inst_addr,
    output logic [DATA_SIZE-1:0] inst_rd_data,
    output logic                 inst_ack,
    input  logic                 data_rd_en,
    input  logic                 data_wr_en,
    input  logic [ADDR_SIZE-1:0] data_addr,
    input  logic [DATA_SIZE-1:0] data_wr_data,
    input  logic [BYTE_NUM-1:0]  data_byte_en,
    output logic [DATA_SIZE-1:0] data_rd_data,
    output logic                 data_ack,
    output logic                 mem_rd_en,
    output logic                 mem_wr_en,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0] mem_wr_data,
    output logic [BYTE_NUM-1:0]  mem_byte_en,
    input  logic [DATA_SIZE-1:0] mem_rd_data,
    input  logic                 mem_ack
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SERVE_INST,
        ST_SERVE_DATA
    } state_e;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    state_e               state_q, state_d;
    src_e                 last_served_q, last_served_d;
    logic                 mem_rd_en_q, mem_rd_en_d;
    logic                 mem_wr_en_q, mem_wr_en_d;
    logic [ADDR_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_SIZE-1:0] mem_wr_data_q, mem_wr_data_d;
    logic [BYTE_NUM-1:0]  mem_byte_en_q, mem_byte_en_d;

    logic inst_pend, data_pend;
    logic grant_inst, grant_data;

    assign inst_pend = inst_rd_en;
    assign data_pend = data_rd_en | data_wr_en;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d       = state_q;
        last_served_d = last_served_q;
        mem_rd_en_d   = mem_rd_en_q;
        mem_wr_en_d   = mem_wr_en_q;
        mem_addr_d    = mem_addr_q;
        mem_wr_data_d = mem_wr_data_q;
        mem_byte_en_d = mem_byte_en_q;
        grant_inst    = 1'b0;
        grant_data    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (inst_pend && data_pend) begin
                    if (last_served_q == SRC_INST) grant_data = 1'b1;
                    else                           grant_inst = 1'b1;
                end else if (data_pend) begin
                    grant_data = 1'b1;
                end else if (inst_pend) begin
                    grant_inst = 1'b1;
                end
            end
            // On completion only the other side is eligible; its request is handed over with no gap.
            ST_SERVE_INST: begin
                if (mem_ack) begin
                    if (data_pend) begin
                        grant_data = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        mem_rd_en_d = 1'b0;
                        mem_wr_en_d = 1'b0;
                    end
                end
            end
            ST_SERVE_DATA: begin
                if (mem_ack) begin
                    if (inst_pend) begin
                        grant_inst = 1'b1;
                    end else begin
                        state_d     = ST_IDLE;
                        mem_rd_en_d = 1'b0;
                        mem_wr_en_d = 1'b0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (grant_inst) begin
            state_d       = ST_SERVE_INST;
            last_served_d = SRC_INST;
            mem_rd_en_d   = 1'b1;
            mem_wr_en_d   = 1'b0;
            mem_addr_d    = inst_addr;
            mem_byte_en_d = '1;
        end
        if (grant_data) begin
            state_d       = ST_SERVE_DATA;
            last_served_d = SRC_DATA;
            mem_rd_en_d   = data_rd_en;
            mem_wr_en_d   = data_wr_en;
            mem_addr_d    = data_addr;
            mem_wr_data_d = data_wr_data;
            mem_byte_en_d = data_byte_en;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            last_served_q <= SRC_INST;
            mem_rd_en_q   <= 1'b0;
            mem_wr_en_q   <= 1'b0;
            mem_addr_q    <= '0;
            mem_wr_data_q <= '0;
            mem_byte_en_q <= '0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_wr_en_q   <= mem_wr_en_d;
            mem_addr_q    <= mem_addr_d;
            mem_wr_data_q <= mem_wr_data_d;
            mem_byte_en_q <= mem_byte_en_d;
        end
    end

    assign mem_rd_en    = mem_rd_en_q;
    assign mem_wr_en    = mem_wr_en_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wr_data  = mem_wr_data_q;
    assign mem_byte_en  = mem_byte_en_q;

    assign inst_ack     = (state_q == ST_SERVE_INST) && mem_ack;
    assign data_ack     = (state_q == ST_SERVE_DATA) && mem_ack;
    assign inst_rd_data = (state_q == ST_SERVE_INST) ? mem_rd_data : '0;
    assign data_rd_data = (state_q == ST_SERVE_DATA) ? mem_rd_data : '0;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Two-requester arbiter that shares the core's single memory port between instruction fetch and data access (load/store). It sits between the pipeline's fetch and memory stages and the memory/bus interface. It latches each granted request into registers, so memory-side signals stay stable for the whole transaction. It routes `mem_ack` and read data back to the granted requester. Grants alternate, so neither requester can be starved.

## Interface
- `ADDR_SIZE`, 64: address width.
- `DATA_SIZE`, 64: data width.
- `BYTE_NUM`, `DATA_SIZE/8`: byte-enable width.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `inst_rd_en` in 1: fetch read request.
- `inst_addr` in ADDR_SIZE: fetch address.
- `inst_rd_data` out DATA_SIZE: fetch read data.
- `inst_ack` out 1: fetch transaction complete.
- `data_rd_en` in 1: load request.
- `data_wr_en` in 1: store request.
- `data_addr` in ADDR_SIZE: data address.
- `data_wr_data` in DATA_SIZE: store data.
- `data_byte_en` in BYTE_NUM: data byte enables.
- `data_rd_data` out DATA_SIZE: load data.
- `data_ack` out 1: data transaction complete.
- `mem_rd_en`, `mem_wr_en` out 1: shared port enables, registered.
- `mem_addr` out ADDR_SIZE: shared port address, registered.
- `mem_wr_data` out DATA_SIZE: shared port write data, registered.
- `mem_byte_en` out BYTE_NUM: shared port byte enables, registered.
- `mem_rd_data` in DATA_SIZE: shared port read data.
- `mem_ack` in 1: shared port transaction complete.

## Operation

**State machine.** There are three states: Idle, ServeInst and ServeData. A 1-bit register `last_served` records which requester was served most recently (Inst or Data).

**Idle.**
- A requester is pending when `inst_rd_en`, or `data_rd_en | data_wr_en`, is high.
- Only one pending: grant it.
- Both pending: grant the one not equal to `last_served`.
- Reset value of `last_served` is Inst, so Data wins the first tie.

**Grant.**
- In the grant cycle, the granted request is latched into the mem_* registers at the clock edge:
  - Fetch: `mem_rd_en=1`, `mem_wr_en=0`, `mem_byte_en` all ones.
  - Data: the requester's rd/wr/addr/wr_data/byte_en are copied unchanged. Both rd and wr high is illegal and is forwarded as-is.
- `last_served` is updated to the granted requester at the same edge.

**ServeX (serving requester X).**
- The mem_* registers hold their values until `mem_ack`.
- Requester inputs are ignored; changing or dropping a request mid-transaction has no effect.
- `X_ack = mem_ack`, combinationally.
- `X_rd_data = mem_rd_data` while in ServeX; otherwise 0.
- The other requester's ack is 0.

**On `mem_ack` in ServeX.**
- X is ineligible in this cycle, because its request is still held.
- Other requester pending: latch it and go directly to ServeOther. This gives a back-to-back transaction with no idle gap, and `last_served` becomes Other.
- Other requester not pending: clear `mem_rd_en`/`mem_wr_en` to 0 and go to Idle. Address/data registers keep their old values.

**Other rules.**
- `mem_ack` in Idle is ignored; both acks stay 0.
- `inst_ack` and `data_ack` are never high in the same cycle.

## Timing
- **Reset values:** state Idle; `mem_rd_en=0`, `mem_wr_en=0`, `mem_addr=0`, `mem_wr_data=0`, `mem_byte_en=0`; `inst_ack=0`, `data_ack=0`; both rd_data outputs 0; `last_served` Inst.
- **Reset mid-transaction:** all of the above take effect immediately and asynchronously. The outstanding transaction is abandoned, and a later `mem_ack` is ignored in Idle.
- **Request to memory:** a request sampled in Idle at edge N drives mem_* from cycle N+1. Minimum request-to-ack latency is 1 cycle, when memory acks in the first ServeX cycle.
- **Ack:** the requester ack is asserted in the same cycle as `mem_ack`.
- **Same requester twice:** consecutive accesses by one requester always see at least one Idle cycle between them.
- **Fairness bound:** with both requesters continuously requesting, grants alternate strictly I/D/I/D. A waiting requester waits at most one foreign transaction.

## Test plan
- **Reset:** assert `reset` while in ServeData with `mem_wr_en=1`. Expect all outputs 0 in the same cycle. After release, a `mem_ack` pulse gives `data_ack=0`.
- **Single fetch:** `inst_rd_en=1`, `inst_addr=0x1000` at edge 0; memory acks at edge 3 with `rd_data=0xDEADBEEF`. Expect `mem_rd_en=1` and `mem_addr=0x1000` in cycles 1–3, `inst_ack=1` and `inst_rd_data=0xDEADBEEF` in cycle 3, Idle in cycle 4.
- **Simultaneous requests from reset:** fetch at 0x2000 and store at 0x3000 (`wr_data=0x55`, `byte_en=0x0F`) in the same cycle. Expect the store served first with `mem_wr_en=1`, `mem_byte_en=0x0F`. The fetch at 0x2000 follows immediately, with no Idle cycle, after `data_ack`.
- **Mid-transaction changes:** in ServeInst, change `inst_addr` to 0x4000 and drop `inst_rd_en`. Expect `mem_addr` to stay at its latched value and `inst_ack` to still fire with `mem_ack`.
- **Continuous contention:** both requesters held high for 6 acks. Expect the grant order D, I, D, I, D, I and never two consecutive acks to the same requester.
- **Stray ack:** `mem_ack` pulsed in Idle. Expect no requester ack and the state to remain Idle.
